// File: rtl/result_stream_buffer.sv
// Double-buffered matrix snapshot and byte streamer for the systolic array output.
// Each capture freezes one NxN accumulator matrix; bytes leave on a valid/ready stream.
module result_stream_buffer #(
  parameter int N     = 2,
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N*N*ACC_W-1:0]   results,
  input  logic                   narrow,
  input  logic                   cap_valid,
  output logic                   cap_ready,
  input  logic                   flush,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   out_sat
);

  localparam int NE  = N * N;
  localparam int BPE = ACC_W / OUT_W;
  localparam int EW  = (NE > 1) ? $clog2(NE) : 1;
  localparam int BW  = (BPE > 1) ? $clog2(BPE) : 1;
  localparam logic [EW-1:0] EL_LAST = EW'(NE - 1);
  localparam logic [BW-1:0] BY_LAST = BW'(BPE - 1);

  logic [NE*ACC_W-1:0] mem [2];
  logic [1:0]          full;
  logic [1:0]          nar;
  logic [1:0]          sat;
  logic                wr_bank;
  logic                rd_bank;
  logic [EW-1:0]       el_idx;
  logic [BW-1:0]       by_idx;

  logic                cap_fire;
  logic                beat;
  logic                cap_sat;
  logic                last_byte;
  logic [ACC_W-1:0]    elem;
  logic [ACC_W-1:0]    shifted;
  logic [OUT_W-1:0]    sel_byte;

  // An element fits in OUT_W signed bits when its top bits are pure sign extension.
  function automatic logic ovf(input logic [ACC_W-1:0] v);
    logic [ACC_W-OUT_W:0] top;
    top = v[ACC_W-1:OUT_W-1];
    return !((&top) || !(|top));
  endfunction

  function automatic logic [OUT_W-1:0] clamp(input logic [ACC_W-1:0] v);
    if (!ovf(v))
      return v[OUT_W-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  always_comb begin
    cap_sat = 1'b0;
    for (int e = 0; e < NE; e++)
      cap_sat = cap_sat | ovf(results[e*ACC_W +: ACC_W]);
  end

  always_comb begin
    elem      = mem[rd_bank][int'(el_idx)*ACC_W +: ACC_W];
    shifted   = elem >> ((BPE - 1 - int'(by_idx)) * OUT_W);
    sel_byte  = nar[rd_bank] ? clamp(elem) : shifted[OUT_W-1:0];
    last_byte = (el_idx == EL_LAST) &&
                (nar[rd_bank] || (by_idx == BY_LAST));
  end

  assign cap_ready = ~(&full);
  assign out_valid = full[rd_bank];
  assign out_last  = out_valid & last_byte;
  assign out_data  = out_valid ? sel_byte : '0;
  assign out_sat   = out_valid & nar[rd_bank] & sat[rd_bank];
  assign cap_fire  = cap_valid & cap_ready;
  assign beat      = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        mem[b] <= '0;
      full    <= '0;
      nar     <= '0;
      sat     <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      el_idx  <= '0;
      by_idx  <= '0;
    end else if (flush) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      el_idx  <= '0;
      by_idx  <= '0;
    end else begin
      if (cap_fire) begin
        mem[wr_bank]  <= results;
        full[wr_bank] <= 1'b1;
        nar[wr_bank]  <= narrow;
        sat[wr_bank]  <= cap_sat;
        wr_bank       <= ~wr_bank;
      end
      // Capture always targets the empty bank, so it never collides with this clear.
      if (beat) begin
        if (last_byte) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
          el_idx        <= '0;
          by_idx        <= '0;
        end else if (nar[rd_bank] || by_idx == BY_LAST) begin
          by_idx <= '0;
          el_idx <= el_idx + 1'b1;
        end else begin
          by_idx <= by_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_stream_buffer.sv
// Directed bench for result_stream_buffer: vector table plus backpressure
// and asynchronous-reset sequences.
module tb_result_stream_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] results;
  logic        narrow;
  logic        cap_valid;
  logic        cap_ready;
  logic        flush;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_sat;

  result_stream_buffer #(.N(2), .ACC_W(16), .OUT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .results(results), .narrow(narrow),
    .cap_valid(cap_valid), .cap_ready(cap_ready), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] D  = {16'h7FFF, 16'h0100, 16'hFF80, 16'h1234};
  localparam logic [63:0] R2 = {16'h007F, 16'h0000, 16'hFFFB, 16'h0005};
  localparam logic [63:0] D2 = {16'h0708, 16'h0506, 16'h0304, 16'h0102};
  localparam logic [63:0] D3 = {4{16'hEEEE}};

  typedef struct {
    logic        cv;
    logic        nar;
    logic        ordy;
    logic        fl;
    logic [63:0] res;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic        es;
    logic        cr;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(logic cv, logic nar, logic ordy, logic fl,
                              logic [63:0] res, logic ev, logic [7:0] ed,
                              logic el, logic es, logic cr);
    vec_t v;
    v.cv = cv; v.nar = nar; v.ordy = ordy; v.fl = fl; v.res = res;
    v.ev = ev; v.ed = ed; v.el = el; v.es = es; v.cr = cr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // streaming rows with out_ready=1, no capture
  task automatic add_stream(input logic [63:0] res, input logic [7:0] b [],
                            input logic s, input logic cr_last);
    for (int i = 0; i < b.size(); i++)
      tbl.push_back(mk(0, 0, 1, 0, res, 1, b[i], i == b.size() - 1, s,
                       (i == b.size() - 1) ? cr_last : 1'b1));
  endtask

  logic [7:0] full_d  [] = '{8'h12, 8'h34, 8'hFF, 8'h80,
                             8'h01, 8'h00, 8'h7F, 8'hFF};
  logic [7:0] nar_d   [] = '{8'h7F, 8'h80, 8'h7F, 8'h7F};
  logic [7:0] nar_r2  [] = '{8'h05, 8'hFB, 8'h00, 8'h7F};
  logic [7:0] full_d2 [] = '{8'h01, 8'h02, 8'h03, 8'h04,
                             8'h05, 8'h06, 8'h07, 8'h08};

  initial begin
    rst_n = 1'b0; results = '0; narrow = 0; cap_valid = 0;
    flush = 0; out_ready = 0;
    #12 rst_n = 1'b1;

    // reset state, then full-mode stream
    tbl.push_back(mk(0, 0, 1, 0, D, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, D, 0, 8'h00, 0, 0, 1));
    add_stream(D, full_d, 0, 1);
    tbl.push_back(mk(0, 0, 1, 0, D, 0, 8'h00, 0, 0, 1));
    // narrow, saturating; narrow drops to 0 after capture
    tbl.push_back(mk(1, 1, 1, 0, D, 0, 8'h00, 0, 0, 1));
    add_stream(D, nar_d, 1, 1);
    tbl.push_back(mk(0, 0, 1, 0, D, 0, 8'h00, 0, 0, 1));
    // narrow, all in range
    tbl.push_back(mk(1, 1, 1, 0, R2, 0, 8'h00, 0, 0, 1));
    add_stream(R2, nar_r2, 0, 1);
    tbl.push_back(mk(0, 0, 1, 0, D, 0, 8'h00, 0, 0, 1));
    // flush mid-stream overriding a beat, then restart from byte 0
    tbl.push_back(mk(1, 0, 1, 0, D, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, D, 1, 8'h12, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, D, 1, 8'h34, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, D, 0, 8'h00, 0, 0, 1));
    add_stream(D, full_d, 0, 1);
    tbl.push_back(mk(0, 0, 1, 0, D, 0, 8'h00, 0, 0, 1));
    // double buffer: three captures with out_ready=0
    tbl.push_back(mk(1, 0, 0, 0, D,  0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, D2, 1, 8'h12, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, D3, 1, 8'h12, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, D3, 1, 8'h12, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 1, 0, D, 1, full_d[i], i == 7, 0, 0));
    add_stream(D2, full_d2, 0, 1);
    tbl.push_back(mk(0, 0, 1, 0, D, 0, 8'h00, 0, 0, 1));
    // capture on the same edge as the final byte: no bubble
    tbl.push_back(mk(1, 0, 1, 0, D, 0, 8'h00, 0, 0, 1));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0, 0, 1, 0, D, 1, full_d[i], 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, D2, 1, 8'hFF, 1, 0, 1));
    add_stream(D2, full_d2, 0, 1);
    tbl.push_back(mk(0, 0, 1, 0, D, 0, 8'h00, 0, 0, 1));

    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {20'd0, out_valid, out_data, out_last, out_sat, cap_ready},
          {20'd0, tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].es, tbl[i].cr});
      cap_valid = tbl[i].cv; narrow = tbl[i].nar;
      out_ready = tbl[i].ordy; flush = tbl[i].fl; results = tbl[i].res;
    end
    @(negedge clk);
    cap_valid = 0; flush = 0; out_ready = 0;

    // backpressure: out_ready 1,0,0,1 repeating
    begin
      int         k;
      logic       rdy;
      logic       prev_stall;
      logic [7:0] prev_data;
      cap_valid = 1; results = D; narrow = 0;
      @(negedge clk);
      cap_valid = 0;
      k = 0; prev_stall = 0; prev_data = '0;
      for (int i = 0; i < 40 && k < 8; i++) begin
        if (prev_stall)
          chk("bp_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
        rdy = (i % 4 == 0) || (i % 4 == 3);
        out_ready = rdy;
        if (out_valid && rdy) begin
          chk($sformatf("bp_byte%0d", k), {24'd0, out_data}, {24'd0, full_d[k]});
          chk($sformatf("bp_last%0d", k), {31'd0, out_last}, {31'd0, k == 7});
          k++;
        end
        prev_stall = out_valid && !rdy;
        prev_data  = out_data;
        @(negedge clk);
      end
      chk("bp_count", k, 8);
      chk("bp_done", {31'd0, out_valid}, 32'd0);
      out_ready = 0;
    end

    // asynchronous reset mid-stream
    @(negedge clk);
    cap_valid = 1; results = D; out_ready = 1;
    @(negedge clk);
    cap_valid = 0;
    chk("ar_b0", {24'd0, out_data}, 32'h12);
    @(negedge clk);
    chk("ar_b1", {24'd0, out_data}, 32'h34);
    @(negedge clk);
    chk("ar_b2", {24'd0, out_data}, 32'hFF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out", {20'd0, out_valid, out_data, out_last, out_sat, cap_ready},
        {20'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    cap_valid = 1; results = D2;
    @(negedge clk);
    cap_valid = 0;
    chk("ar_restart", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h01});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
